// File: rtl/bht_ctrl_if.sv
// bht_ctrl_if - signal bundle between the fetch/execute stages, the BHT
// controller and the BHT LRU unit.
//
//   master : driven by the pipeline side (lookup, update, flush) and by the
//            LRU unit (lru_item); observes lookup results, upd_ready, touch.
//   slave  : the bht_ctrl side.
//
// Signals:
//   lookup_en/lookup_pc        -> fetch lookup request
//   lookup_hit/taken/target    <- combinational lookup result
//   upd_valid/upd_pc/taken/tgt -> execute-stage update request
//   upd_ready                  <- controller can accept an update
//   flush                      -> invalidate whole table
//   touch_en/touch_item        <- one-hot touch to the LRU unit
//   lru_item                   -> one-hot least-recently-used entry from LRU
interface bht_ctrl_if #(
    parameter int NItem       = 8,
    parameter int AddrWidth   = 30,
    parameter int TargetWidth = 32
);
    logic                   lookup_en;
    logic [AddrWidth-1:0]   lookup_pc;
    logic                   lookup_hit;
    logic                   lookup_taken;
    logic [TargetWidth-1:0] lookup_target;
    logic                   upd_valid;
    logic                   upd_ready;
    logic [AddrWidth-1:0]   upd_pc;
    logic                   upd_taken;
    logic [TargetWidth-1:0] upd_target;
    logic                   flush;
    logic                   touch_en;
    logic [NItem-1:0]       touch_item;
    logic [NItem-1:0]       lru_item;

    modport master (
        output lookup_en, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
               flush, lru_item,
        input  lookup_hit, lookup_taken, lookup_target, upd_ready, touch_en,
               touch_item
    );

    modport slave (
        input  lookup_en, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
               flush, lru_item,
        output lookup_hit, lookup_taken, lookup_target, upd_ready, touch_en,
               touch_item
    );
endinterface

// File: rtl/bht_ctrl.sv
// bht_ctrl - fully associative branch history table controller.
// Serves combinational fetch lookups, sequences execute-stage updates into
// the table (hit: saturating counter update; miss: allocate a victim) and is
// the sole driver of the LRU unit's one-hot touch port.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         bht_ctrl_if.slave (lookup, update handshake, flush, LRU touch)
//
// Build option:
//   BHT_LOOKUP_TOUCH_EN  when defined, an IDLE-cycle lookup hit also touches
//                        the LRU (update touches still take priority). When
//                        undefined, only writes touch the LRU, so replacement
//                        is least-recently-updated.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for an update (upd_ready=1 unless flush)
// WRITE | captured update is written into the hit or victim entry
module bht_ctrl #(
    parameter int NItem       = 8,
    parameter int AddrWidth   = 30,
    parameter int TargetWidth = 32
) (
    input logic      clk,
    input logic      rst_n,
    bht_ctrl_if.slave bus
);
    typedef enum logic {IDLE, WRITE} state_e;

    state_e                 state_q, state_d;
    logic [NItem-1:0]       valid_q, valid_d;
    logic [AddrWidth-1:0]   tag_q [NItem];
    logic [AddrWidth-1:0]   tag_d [NItem];
    logic [1:0]             cnt_q [NItem];
    logic [1:0]             cnt_d [NItem];
    logic [TargetWidth-1:0] tgt_q [NItem];
    logic [TargetWidth-1:0] tgt_d [NItem];
    logic [AddrWidth-1:0]   hold_pc_q, hold_pc_d;
    logic                   hold_taken_q, hold_taken_d;
    logic [TargetWidth-1:0] hold_target_q, hold_target_d;

    logic [NItem-1:0]       lk_match, upd_match, inv_first, wr_vec;
    logic                   lk_taken, upd_hit, any_inv;
    logic [TargetWidth-1:0] lk_target;

`ifndef BHT_LOOKUP_TOUCH_EN
    logic unused_lookup_en;
    assign unused_lookup_en = bus.lookup_en;
`endif

    // Tag compares: lookup side uses live lookup_pc, update side uses only
    // the holding register so the write target is stable in WRITE.
    always_comb begin
        lk_match  = '0;
        upd_match = '0;
        lk_taken  = 1'b0;
        lk_target = '0;
        for (int i = 0; i < NItem; i++) begin
            lk_match[i]  = valid_q[i] && (tag_q[i] == bus.lookup_pc);
            upd_match[i] = valid_q[i] && (tag_q[i] == hold_pc_q);
            lk_taken     = lk_taken | (lk_match[i] & cnt_q[i][1]);
            lk_target    = lk_target | ({TargetWidth{lk_match[i]}} & tgt_q[i]);
        end
    end

    assign bus.lookup_hit    = |lk_match;
    assign bus.lookup_taken  = lk_taken;
    assign bus.lookup_target = lk_target;
    assign upd_hit           = |upd_match;

    // Lowest-index invalid entry is preferred over the LRU victim.
    always_comb begin
        inv_first = '0;
        any_inv   = 1'b0;
        for (int i = 0; i < NItem; i++) begin
            if (!valid_q[i] && !any_inv) begin
                inv_first[i] = 1'b1;
                any_inv      = 1'b1;
            end
        end
    end

    assign wr_vec = upd_hit ? upd_match : (any_inv ? inv_first : bus.lru_item);

    always_comb begin
        state_d        = state_q;
        valid_d        = valid_q;
        tag_d          = tag_q;
        cnt_d          = cnt_q;
        tgt_d          = tgt_q;
        hold_pc_d      = hold_pc_q;
        hold_taken_d   = hold_taken_q;
        hold_target_d  = hold_target_q;
        bus.touch_en   = 1'b0;
        bus.touch_item = '0;
        bus.upd_ready  = (state_q == IDLE) && !bus.flush;

        if (bus.flush) begin
            // Drops any pending write; tags/counters/targets are left as-is.
            state_d = IDLE;
            valid_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.upd_valid) begin
                        hold_pc_d     = bus.upd_pc;
                        hold_taken_d  = bus.upd_taken;
                        hold_target_d = bus.upd_target;
                        state_d       = WRITE;
                    end
`ifdef BHT_LOOKUP_TOUCH_EN
                    if (bus.lookup_en && bus.lookup_hit) begin
                        bus.touch_en   = 1'b1;
                        bus.touch_item = lk_match;
                    end
`endif
                end
                WRITE: begin
                    bus.touch_en   = 1'b1;
                    bus.touch_item = wr_vec;
                    for (int i = 0; i < NItem; i++) begin
                        if (wr_vec[i]) begin
                            if (upd_hit) begin
                                if (hold_taken_q) begin
                                    if (cnt_q[i] != 2'b11) cnt_d[i] = cnt_q[i] + 2'd1;
                                    tgt_d[i] = hold_target_q;
                                end else if (cnt_q[i] != 2'b00) begin
                                    cnt_d[i] = cnt_q[i] - 2'd1;
                                end
                            end else begin
                                valid_d[i] = 1'b1;
                                tag_d[i]   = hold_pc_q;
                                tgt_d[i]   = hold_target_q;
                                cnt_d[i]   = hold_taken_q ? 2'b10 : 2'b01;
                            end
                        end
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            tag_q         <= '{default: '0};
            cnt_q         <= '{default: '0};
            tgt_q         <= '{default: '0};
            hold_pc_q     <= '0;
            hold_taken_q  <= 1'b0;
            hold_target_q <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            cnt_q         <= cnt_d;
            tgt_q         <= tgt_d;
            hold_pc_q     <= hold_pc_d;
            hold_taken_q  <= hold_taken_d;
            hold_target_q <= hold_target_d;
        end
    end
endmodule

// File: tb/tb_bht_ctrl.sv
module tb_bht_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    bht_ctrl_if #(.NItem(8), .AddrWidth(30), .TargetWidth(32)) bus ();

    bht_ctrl #(.NItem(8), .AddrWidth(30), .TargetWidth(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic look(input logic [29:0] pc, input logic hit, input logic tk,
                        input logic [31:0] tg);
        bus.lookup_pc = pc;
        #1;
        chk($sformatf("hit_%0h", pc), 32'(bus.lookup_hit), 32'(hit));
        chk($sformatf("taken_%0h", pc), 32'(bus.lookup_taken), 32'(tk));
        chk($sformatf("target_%0h", pc), bus.lookup_target, tg);
    endtask

    // Starts at posedge+1 in IDLE, returns at posedge+1 after the write edge.
    task automatic upd(input logic [29:0] pc, input logic tk, input logic [31:0] tg,
                       input logic [7:0] exp_item);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_taken  = tk;
        bus.upd_target = tg;
        #1;
        chk("upd_ready_idle", 32'(bus.upd_ready), 32'd1);
        @(posedge clk); #1;
        bus.upd_valid = 1'b0;
        #1;
        chk("upd_ready_write", 32'(bus.upd_ready), 32'd0);
        chk("touch_en_write", 32'(bus.touch_en), 32'd1);
        chk("touch_item_write", 32'(bus.touch_item), 32'(exp_item));
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.lookup_en  = 1'b0;
        bus.lookup_pc  = 30'h100;
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_taken  = 1'b0;
        bus.upd_target = '0;
        bus.flush      = 1'b0;
        bus.lru_item   = 8'h01;

        #12;
        chk("rst_upd_ready", 32'(bus.upd_ready), 32'd1);
        chk("rst_touch_en", 32'(bus.touch_en), 32'd0);
        chk("rst_touch_item", 32'(bus.touch_item), 32'd0);
        look(30'h100, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First allocation and counter walk on entry 0
        upd(30'h100, 1'b1, 32'h2000, 8'h01);
        look(30'h100, 1'b1, 1'b1, 32'h2000);          // cnt 2
        upd(30'h100, 1'b0, 32'hAAAA, 8'h01);
        look(30'h100, 1'b1, 1'b0, 32'h2000);          // cnt 1
        upd(30'h100, 1'b0, 32'hBBBB, 8'h01);
        look(30'h100, 1'b1, 1'b0, 32'h2000);          // cnt 0
        upd(30'h100, 1'b1, 32'h2100, 8'h01);
        look(30'h100, 1'b1, 1'b0, 32'h2100);          // cnt 1
        upd(30'h100, 1'b1, 32'h2200, 8'h01);
        look(30'h100, 1'b1, 1'b1, 32'h2200);          // cnt 2
        upd(30'h100, 1'b1, 32'h2300, 8'h01);
        look(30'h100, 1'b1, 1'b1, 32'h2300);          // cnt 3
        upd(30'h100, 1'b1, 32'h2400, 8'h01);
        look(30'h100, 1'b1, 1'b1, 32'h2400);          // saturated at 3
        upd(30'h100, 1'b0, 32'hCCCC, 8'h01);
        look(30'h100, 1'b1, 1'b1, 32'h2400);          // 3 -> 2 still taken

        // Fill entries 1..7; free entries win over lru_item (=entry 0)
        for (int i = 1; i < 8; i++)
            upd(30'h100 + 30'(i), 1'b0, 32'h1000 + 32'(i), 8'(1 << i));
        look(30'h103, 1'b1, 1'b0, 32'h1003);
        look(30'h107, 1'b1, 1'b0, 32'h1007);

        // Table full: LRU picks entry 2
        bus.lru_item = 8'h04;
        upd(30'h200, 1'b1, 32'h9000, 8'h04);
        bus.lru_item = 8'h01;
        look(30'h102, 1'b0, 1'b0, 32'h0);
        look(30'h200, 1'b1, 1'b1, 32'h9000);
        look(30'h100, 1'b1, 1'b1, 32'h2400);

        // IDLE lookup hit on entry 3
        bus.lookup_en = 1'b1;
        bus.lookup_pc = 30'h103;
        #1;
`ifdef BHT_LOOKUP_TOUCH_EN
        chk("lk_touch_en", 32'(bus.touch_en), 32'd1);
        chk("lk_touch_item", 32'(bus.touch_item), 32'h08);
`else
        chk("lk_touch_en", 32'(bus.touch_en), 32'd0);
        chk("lk_touch_item", 32'(bus.touch_item), 32'h00);
`endif
        // Lookup on entry 3 during WRITE to entry 5: update touch wins
        upd(30'h105, 1'b1, 32'h5005, 8'h20);
        bus.lookup_en = 1'b0;
        look(30'h105, 1'b1, 1'b1, 32'h5005);

        // Flush during WRITE
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 30'h300;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h7777;
        bus.lookup_en  = 1'b1;
        bus.lookup_pc  = 30'h103;
        @(posedge clk); #1;
        bus.upd_valid = 1'b0;
        bus.flush     = 1'b1;
        #1;
        chk("flush_touch_en", 32'(bus.touch_en), 32'd0);
        chk("flush_upd_ready", 32'(bus.upd_ready), 32'd0);
        chk("flush_pre_hit", 32'(bus.lookup_hit), 32'd1);
        @(posedge clk); #1;
        bus.flush     = 1'b0;
        bus.lookup_en = 1'b0;
        #1;
        chk("post_flush_ready", 32'(bus.upd_ready), 32'd1);
        chk("post_flush_touch_en", 32'(bus.touch_en), 32'd0);
        look(30'h300, 1'b0, 1'b0, 32'h0);
        look(30'h103, 1'b0, 1'b0, 32'h0);
        look(30'h100, 1'b0, 1'b0, 32'h0);

        // Flush beats a same-cycle update request
        bus.upd_valid = 1'b1;
        bus.upd_pc    = 30'h500;
        bus.flush     = 1'b1;
        #1;
        chk("flush_prio_ready", 32'(bus.upd_ready), 32'd0);
        @(posedge clk); #1;
        bus.upd_valid = 1'b0;
        bus.flush     = 1'b0;
        #1;
        chk("flush_prio_touch_en", 32'(bus.touch_en), 32'd0);
        chk("flush_prio_ready2", 32'(bus.upd_ready), 32'd1);
        @(posedge clk); #1;
        look(30'h500, 1'b0, 1'b0, 32'h0);

        // Refill after flush starts from entry 0
        upd(30'h300, 1'b1, 32'h7777, 8'h01);
        look(30'h300, 1'b1, 1'b1, 32'h7777);

        // Reset asserted while in WRITE
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 30'h400;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h4444;
        @(posedge clk); #1;
        bus.upd_valid = 1'b0;
        rst_n         = 1'b0;
        #1;
        chk("rstw_upd_ready", 32'(bus.upd_ready), 32'd1);
        chk("rstw_touch_en", 32'(bus.touch_en), 32'd0);
        chk("rstw_touch_item", 32'(bus.touch_item), 32'd0);
        look(30'h300, 1'b0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstw_idle_touch", 32'(bus.touch_en), 32'd0);
        look(30'h400, 1'b0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
